// File: rtl/gen_stream_pkg.sv
// Shared types and default widths for the generator-stream collector.
// The result struct is sized for the default widths.
package gen_stream_pkg;

    localparam int GEN_WIDTH_DEF = 32;
    localparam int SUM_WIDTH_DEF = 48;
    localparam int CNT_WIDTH_DEF = 16;
    localparam int MASK_LEN      = 8;
    localparam int MASK_PTR_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        COLLECT = 2'd2,
        RESULT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_WIDTH_DEF-1:0] count;
        logic [SUM_WIDTH_DEF-1:0] sum0;
        logic [SUM_WIDTH_DEF-1:0] sum1;
        logic [CNT_WIDTH_DEF-1:0] mismatch;
        logic                     timeout;
    } result_t;

endpackage

// File: rtl/gen_ready_throttle.sv
// Rotating ready pattern for the child stream: bit0 of READY_MASK is offered first,
// and the pointer advances every enabled cycle.
module gen_ready_throttle
    import gen_stream_pkg::*;
#(
    parameter logic [MASK_LEN-1:0] READY_MASK = 8'hFF
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic gen_ready
);

    logic [MASK_PTR_W-1:0] ptr_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            ptr_reg <= '0;
        end else if (enable) begin
            ptr_reg <= ptr_reg + MASK_PTR_W'(1);
        end
    end

    assign gen_ready = enable & READY_MASK[ptr_reg];

endmodule

// File: rtl/gen_stream_collector.sv
// Launches a child generator, drains its stream under a ready throttle and reduces it
// to one result beat: beat count, two signed sums and a mismatch count.
module gen_stream_collector
    import gen_stream_pkg::*;
#(
    parameter int                  WIDTH      = 32,
    parameter int                  SUM_WIDTH  = 48,
    parameter int                  CNT_WIDTH  = 16,
    parameter logic [MASK_LEN-1:0] READY_MASK = 8'hFF,
    parameter int                  MAX_IDLE   = 1024
) (
    input  logic                 _clock,
    input  logic                 _reset,
    input  logic                 _start,
    input  logic                 _ready,
    output logic                 _done,
    output logic                 _valid,
    output logic [CNT_WIDTH-1:0] _0,
    output logic [SUM_WIDTH-1:0] _1,
    output logic [SUM_WIDTH-1:0] _2,
    output logic [CNT_WIDTH-1:0] _3,
    output logic                 timeout,
    output logic                 gen_start,
    output logic                 gen_ready,
    input  logic                 gen_valid,
    input  logic                 gen_done,
    input  logic [WIDTH-1:0]     gen_0,
    input  logic [WIDTH-1:0]     gen_1
);

    localparam int IDLE_W = $clog2(MAX_IDLE + 1);

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic [CNT_WIDTH-1:0] mis_reg, mis_next;
    logic [SUM_WIDTH-1:0] sum0_reg, sum0_next;
    logic [SUM_WIDTH-1:0] sum1_reg, sum1_next;
    logic                 timeout_reg, timeout_next;
    logic [IDLE_W-1:0]    idle_reg, idle_next;

    logic                 collecting;
    logic                 launching;
    logic                 accept;
    logic                 stream_end;
    logic [SUM_WIDTH-1:0] sext_0;
    logic [SUM_WIDTH-1:0] sext_1;

    assign collecting = (state_reg == COLLECT);
    assign launching  = (state_reg == LAUNCH);

    // Pointer restarts at bit0 on every launch so each run sees the same pattern.
    gen_ready_throttle #(
        .READY_MASK(READY_MASK)
    ) u_throttle (
        .clk      (_clock),
        .srst     (_reset),
        .clear    (launching),
        .enable   (collecting),
        .gen_ready(gen_ready)
    );

    assign accept     = collecting & gen_valid & gen_ready;
    assign stream_end = collecting & gen_done & gen_ready;
    assign sext_0     = {{(SUM_WIDTH - WIDTH){gen_0[WIDTH-1]}}, gen_0};
    assign sext_1     = {{(SUM_WIDTH - WIDTH){gen_1[WIDTH-1]}}, gen_1};

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        mis_next     = mis_reg;
        sum0_next    = sum0_reg;
        sum1_next    = sum1_reg;
        timeout_next = timeout_reg;
        idle_next    = idle_reg;
        case (state_reg)
            IDLE: begin
                if (_start) begin
                    state_next   = LAUNCH;
                    count_next   = '0;
                    mis_next     = '0;
                    sum0_next    = '0;
                    sum1_next    = '0;
                    timeout_next = 1'b0;
                end
            end
            LAUNCH: begin
                state_next = COLLECT;
                idle_next  = '0;
            end
            COLLECT: begin
                if (accept) begin
                    if (count_reg != '1) count_next = count_reg + CNT_WIDTH'(1);
                    if (gen_0 != gen_1 && mis_reg != '1) mis_next = mis_reg + CNT_WIDTH'(1);
                    sum0_next = sum0_reg + sext_0;
                    sum1_next = sum1_reg + sext_1;
                    idle_next = '0;
                end else begin
                    idle_next = idle_reg + IDLE_W'(1);
                end
                // A real end of stream wins over a simultaneous idle expiry.
                if (stream_end) begin
                    state_next = RESULT;
                end else if (!accept && idle_reg == IDLE_W'(MAX_IDLE - 1)) begin
                    state_next   = RESULT;
                    timeout_next = 1'b1;
                end
            end
            RESULT: begin
                if (_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            mis_reg     <= '0;
            sum0_reg    <= '0;
            sum1_reg    <= '0;
            timeout_reg <= 1'b0;
            idle_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            mis_reg     <= mis_next;
            sum0_reg    <= sum0_next;
            sum1_reg    <= sum1_next;
            timeout_reg <= timeout_next;
            idle_reg    <= idle_next;
        end
    end

    assign _valid    = (state_reg == RESULT);
    assign _done     = (state_reg == RESULT);
    assign gen_start = launching;
    assign _0        = count_reg;
    assign _1        = sum0_reg;
    assign _2        = sum1_reg;
    assign _3        = mis_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_gen_stream_collector.sv
// Drives two collectors (no throttle / alternating throttle) from one shared child
// stream and compares each result beat with a reduction computed from the beat list.
module tb_gen_stream_collector;
    import gen_stream_pkg::*;

    logic clk, rst, start, rdy;

    logic        a_done, a_valid, a_to, gs_a, gr_a;
    logic        b_done, b_valid, b_to, gs_b, gr_b;
    logic [15:0] a_0, a_3, b_0, b_3;
    logic [47:0] a_1, a_2, b_1, b_2;

    logic        gv  [2];
    logic        gdn [2];
    logic [31:0] g0  [2];
    logic [31:0] g1  [2];

    result_t got_a, got_b;

    // Child stream description shared by both child instances.
    logic signed [31:0] sa[$];
    logic signed [31:0] sb[$];
    bit dwl, mute, gaps_en;

    bit run [2];
    int ptr [2];
    bit gap_prev [2];

    int total = 0;
    int bad = 0;
    logic [3:0] rdy_hist_b;

    gen_stream_collector #(.READY_MASK(8'hFF), .MAX_IDLE(16)) dut_a (
        ._clock(clk), ._reset(rst), ._start(start), ._ready(rdy),
        ._done(a_done), ._valid(a_valid), ._0(a_0), ._1(a_1), ._2(a_2), ._3(a_3),
        .timeout(a_to), .gen_start(gs_a), .gen_ready(gr_a),
        .gen_valid(gv[0]), .gen_done(gdn[0]), .gen_0(g0[0]), .gen_1(g1[0])
    );

    gen_stream_collector #(.READY_MASK(8'b0101_0101), .MAX_IDLE(16)) dut_b (
        ._clock(clk), ._reset(rst), ._start(start), ._ready(rdy),
        ._done(b_done), ._valid(b_valid), ._0(b_0), ._1(b_1), ._2(b_2), ._3(b_3),
        .timeout(b_to), .gen_start(gs_b), .gen_ready(gr_b),
        .gen_valid(gv[1]), .gen_done(gdn[1]), .gen_0(g0[1]), .gen_1(g1[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        got_a = '{count: a_0, sum0: a_1, sum1: a_2, mismatch: a_3, timeout: a_to};
        got_b = '{count: b_0, sum0: b_1, sum1: b_2, mismatch: b_3, timeout: b_to};
    end

    // Behavioural child: each beat is held until accepted; done follows the last beat
    // or rides along with it.
    always @(posedge clk) begin
        logic rs [2];
        logic st [2];
        bit gap;
        rs[0] = gr_a; rs[1] = gr_b;
        st[0] = gs_a; st[1] = gs_b;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                run[i] = 1'b0;
                ptr[i] = 0;
            end else if (st[i]) begin
                run[i] = 1'b1;
                ptr[i] = 0;
            end else if (run[i] && rs[i]) begin
                if (gdn[i]) run[i] = 1'b0;
                else if (gv[i]) ptr[i]++;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            gap = gaps_en && !gap_prev[i] && ($urandom_range(0, 2) == 0);
            gap_prev[i] = gap;
            gv[i]  = run[i] && !mute && !gap && (ptr[i] < sa.size());
            gdn[i] = run[i] && !mute && (dwl ? (!gap && ptr[i] == sa.size() - 1)
                                             : (ptr[i] >= sa.size()));
            g0[i]  = (ptr[i] < sa.size()) ? sa[ptr[i]] : 32'd0;
            g1[i]  = (ptr[i] < sb.size()) ? sb[ptr[i]] : 32'd0;
        end
    end

    function automatic result_t model(input bit muted);
        result_t r;
        longint  s0, s1;
        int      c, m;
        r = '0; s0 = 0; s1 = 0; c = 0; m = 0;
        if (muted) begin
            r.timeout = 1'b1;
            return r;
        end
        foreach (sa[k]) begin
            c++;
            s0 += longint'(sa[k]);
            s1 += longint'(sb[k]);
            if (sa[k] != sb[k]) m++;
        end
        r.count    = (c > 65535) ? 16'hFFFF : 16'(c);
        r.mismatch = (m > 65535) ? 16'hFFFF : 16'(m);
        r.sum0     = 48'(s0);
        r.sum1     = 48'(s1);
        return r;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic check_res(input string name, input result_t got, input result_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got cnt=%0d s0=%0d s1=%0d mis=%0d to=%0b want cnt=%0d s0=%0d s1=%0d mis=%0d to=%0b",
                     name, got.count, $signed(got.sum0), $signed(got.sum1), got.mismatch, got.timeout,
                     exp.count, $signed(exp.sum0), $signed(exp.sum1), exp.mismatch, exp.timeout);
        end
        $display("txn %s: cnt=%0d s0=%0d s1=%0d mis=%0d to=%0b", name, got.count,
                 $signed(got.sum0), $signed(got.sum1), got.mismatch, got.timeout);
    endtask

    // Pulse _start, wait (bounded) for both result beats and compare them.
    task automatic run_txn(input string name, input result_t exp, input int exp_lat);
        int cyc, lat_a, lat_b;
        cyc = 0; lat_a = 0; lat_b = 0; rdy_hist_b = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_bit({name, "_launch_a"}, gs_a, 1'b1);
        check_bit({name, "_launch_b"}, gs_b, 1'b1);
        while ((lat_a == 0 || lat_b == 0) && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc <= 4) rdy_hist_b[cyc-1] = gr_b;
            if (a_valid && lat_a == 0) begin
                lat_a = cyc;
                check_res({name, "_a"}, got_a, exp);
                check_bit({name, "_done_a"}, a_done, 1'b1);
            end
            if (b_valid && lat_b == 0) begin
                lat_b = cyc;
                check_res({name, "_b"}, got_b, exp);
                check_bit({name, "_done_b"}, b_done, 1'b1);
            end
        end
        if (lat_a == 0) check_bit({name, "_result_timeout_a"}, 1'b0, 1'b1);
        if (lat_b == 0) check_bit({name, "_result_timeout_b"}, 1'b0, 1'b1);
        if (exp_lat > 0) begin
            check_int({name, "_lat_a"}, lat_a, exp_lat);
            check_int({name, "_lat_b"}, lat_b, exp_lat);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input int n, input logic [4:0][31:0] a, input logic [4:0][31:0] b);
        sa.delete(); sb.delete();
        for (int k = 0; k < n; k++) begin
            sa.push_back(a[k]);
            sb.push_back(b[k]);
        end
    endtask

    task automatic check_reset_state(input string name);
        check_bit({name, "_valid_a"}, a_valid, 1'b0);
        check_bit({name, "_done_a"}, a_done, 1'b0);
        check_bit({name, "_gstart_a"}, gs_a, 1'b0);
        check_bit({name, "_gready_a"}, gr_a, 1'b0);
        check_res({name, "_res_a"}, got_a, '0);
        check_bit({name, "_valid_b"}, b_valid, 1'b0);
        check_bit({name, "_gready_b"}, gr_b, 1'b0);
        check_res({name, "_res_b"}, got_b, '0);
    endtask

    typedef struct {
        string            name;
        int               n;
        bit               dwl;
        bit               mute;
        logic [4:0][31:0] a;
        logic [4:0][31:0] b;
        result_t          exp;
        int               lat;
    } vec_t;

    vec_t tbl [4];

    initial begin
        result_t snap_a, snap_b;
        bit saw_launch;
        int k;

        tbl[0].name = "hrange"; tbl[0].n = 5; tbl[0].dwl = 1'b0; tbl[0].mute = 1'b0;
        tbl[0].a = {32'd8, 32'd6, 32'd4, 32'd2, 32'd0};
        tbl[0].b = {32'd8, 32'd6, 32'd4, 32'd2, 32'd0};
        tbl[0].exp = '{count: 16'd5, sum0: 48'd20, sum1: 48'd20, mismatch: 16'd0, timeout: 1'b0};
        tbl[0].lat = 0;
        tbl[1].name = "stub3"; tbl[1].n = 3; tbl[1].dwl = 1'b1; tbl[1].mute = 1'b0;
        tbl[1].a = {32'd0, 32'd0, 32'd5, 32'd3, 32'd1};
        tbl[1].b = {32'd0, 32'd0, 32'd4, 32'd3, 32'd2};
        tbl[1].exp = '{count: 16'd3, sum0: 48'd9, sum1: 48'd9, mismatch: 16'd2, timeout: 1'b0};
        tbl[1].lat = 0;
        tbl[2].name = "mute"; tbl[2].n = 0; tbl[2].dwl = 1'b0; tbl[2].mute = 1'b1;
        tbl[2].a = '0; tbl[2].b = '0;
        tbl[2].exp = '{count: 16'd0, sum0: 48'd0, sum1: 48'd0, mismatch: 16'd0, timeout: 1'b1};
        tbl[2].lat = 17;
        tbl[3].name = "negative"; tbl[3].n = 2; tbl[3].dwl = 1'b0; tbl[3].mute = 1'b0;
        tbl[3].a = {32'd0, 32'd0, 32'd0, -32'sd7, -32'sd5};
        tbl[3].b = {32'd0, 32'd0, 32'd0, -32'sd7, 32'sd5};
        tbl[3].exp = '{count: 16'd2, sum0: 48'hFFFF_FFFF_FFF4, sum1: 48'hFFFF_FFFF_FFFE,
                       mismatch: 16'd1, timeout: 1'b0};
        tbl[3].lat = 0;

        rst = 1'b1; start = 1'b0; rdy = 1'b1;
        dwl = 1'b0; mute = 1'b0; gaps_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            load_vec(tbl[t].n, tbl[t].a, tbl[t].b);
            dwl = tbl[t].dwl; mute = tbl[t].mute;
            run_txn(tbl[t].name, tbl[t].exp, tbl[t].lat);
            if (t == 0) check_int("ready_pattern_b", int'(rdy_hist_b), 5);
        end
        mute = 1'b0;

        // Parent holds off the result for 4 cycles; a second _start must be ignored.
        load_vec(tbl[1].n, tbl[1].a, tbl[1].b);
        dwl = 1'b1;
        rdy = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(a_valid && b_valid) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_bit("hold_reached", a_valid && b_valid, 1'b1);
        snap_a = got_a; snap_b = got_b;
        check_res("hold_value_a", snap_a, tbl[1].exp);
        for (int c = 0; c < 4; c++) begin
            start = (c == 1);
            @(posedge clk); #1;
            check_bit("hold_valid_a", a_valid & a_done, 1'b1);
            check_bit("hold_valid_b", b_valid & b_done, 1'b1);
            check_res("hold_stable_a", got_a, snap_a);
            check_res("hold_stable_b", got_b, snap_b);
        end
        start = 1'b0;
        rdy = 1'b1;
        @(posedge clk); #1;
        check_bit("release_valid_a", a_valid, 1'b0);
        check_bit("release_valid_b", b_valid, 1'b0);
        check_res("release_hold_a", got_a, snap_a);
        saw_launch = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw_launch |= gs_a | gs_b;
        end
        check_bit("no_relaunch", saw_launch, 1'b0);

        // Reset in the middle of a collection, then a clean rerun.
        load_vec(tbl[0].n, tbl[0].a, tbl[0].b);
        dwl = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (a_0 != 16'd2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_int("midreset_two_beats", int'(a_0), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midreset");
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn("rerun", tbl[0].exp, 0);

        // Random streams with gaps against the arithmetic reduction.
        gaps_en = 1'b1;
        for (int t = 0; t < 20; t++) begin
            int n;
            logic [31:0] va, vb;
            sa.delete(); sb.delete();
            n = int'($urandom_range(1, 30));
            for (int j = 0; j < n; j++) begin
                va = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
                vb = ($urandom_range(0, 1) == 1) ? va : $urandom;
                sa.push_back(va);
                sb.push_back(vb);
            end
            dwl = ($urandom_range(0, 1) == 1);
            run_txn($sformatf("rand%0d", t), model(1'b0), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
